mem_block_mover: RTL and testbench
==================================

# mem_block_mover

Block-transfer initiator for the 8x256 data memory. It copies `Len` bytes from `SrcAddr` to `DstAddr` by driving the memory's address, write-enable and write-data ports, and it reads the memory's combinational read data. It sits beside the core as a small DMA-style engine on the same single-address memory port; an external mux grants it the port while `Busy` is high. Copies are overlap-safe (memmove semantics) and addresses wrap modulo 256.

## Interface
Parameters:
- `AW`, 8: address width; memory depth is 2^AW.
- `DW`, 8: data width.

Ports:
- `Clk`  in  1  single clock; all state updates on its rising edge.
- `Reset`  in  1  synchronous, active-low reset; sampled on the rising edge of `Clk`.
- `Start`  in  1  request a copy; sampled only in IDLE.
- `SrcAddr`  in  AW  first source byte address; captured on accepted `Start`.
- `DstAddr`  in  AW  first destination byte address; captured on accepted `Start`.
- `Len`  in  AW  byte count, 0..255; 0 means no transfer.
- `MemAddr`  out  AW  address to the data memory; used for both read and write.
- `MemWrEn`  out  1  write strobe to the data memory.
- `MemWrData`  out  DW  write data to the data memory.
- `MemRdData`  in  DW  combinational read data from the data memory at `MemAddr`.
- `Busy`  out  1  high from the cycle after `Start` is accepted until DONE is left.
- `Done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, READ, WRITE, DONE. State, pointers, `Remaining` and the hold register are registered. All outputs are decoded from registers; there are no combinational paths from inputs to outputs.
- IDLE:
  - `Start`=1 with `Len`=0 → DONE.
  - `Start`=1 with `Len`≠0 → latch pointers and `Remaining`=`Len`, choose direction, → READ.
  - Otherwise stay in IDLE.
- Direction:
  - Descending when `Dst`≠`Src` and ((`Dst`−`Src`) mod 256) < `Len`. Pointers start at `Src`+`Len`−1 and `Dst`+`Len`−1 (mod 256) and decrement.
  - Otherwise ascending: pointers start at `Src` and `Dst` and increment.
- READ: `MemAddr`=src pointer, `MemWrEn`=0. At the edge, the hold register captures `MemRdData` → WRITE.
- WRITE: `MemAddr`=dst pointer, `MemWrEn`=1, `MemWrData`=hold register. At the edge, both pointers step by ±1 mod 256 and `Remaining` decrements.
  - `Remaining`=1 → DONE.
  - Otherwise → READ.
- DONE: `Done`=1 for exactly one cycle, then → IDLE.
- `Busy`=1 in READ, WRITE and DONE.
- `Start` outside IDLE is ignored; it is neither queued nor does it alter the transfer in flight.
- In IDLE and DONE: `MemAddr`=0, `MemWrEn`=0, `MemWrData`=0.
- Reset (`Reset`=0 at an edge): the next state is IDLE; pointers, `Remaining` and the hold register clear to 0. Every output reads 0 in the following cycle.
- Reset mid-transfer aborts the copy. Bytes already written stay written, and no `Done` pulse is produced.

## Timing
- `Start` accepted at edge k → the READ of byte 0 occupies cycle k+1.
- Each byte takes 2 cycles: READ then WRITE. The write of byte i commits at the end of cycle k+2+2i.
- `Done` is high in cycle k+1+2·`Len`.
- `Len`=0: `Done` is high in cycle k+1, and `MemWrEn` is never asserted.
- The earliest next accepted `Start` is at the edge ending the `Done` cycle+1, i.e. in IDLE.
- The READ cycle relies on the memory's combinational read: `MemRdData` must be valid within the same cycle that `MemAddr` is driven.
- Address wrap: 0xFF+1 → 0x00 and 0x00−1 → 0xFF, with no flag or stall.

## Test plan
- Basic ascending copy: mem[0x10..0x13]=11,22,33,44; Start, Src=0x10, Dst=0x40, Len=4 → mem[0x40..0x43]=11,22,33,44; source unchanged; `Done` high exactly 9 cycles after the accepting edge; `Busy` high for 9 cycles.
- Forward overlap: mem[0x20..0x23]=A,B,C,D; Src=0x20, Dst=0x22, Len=4 → descending; mem[0x20..0x25]=A,B,A,B,C,D; the first write address is 0x25.
- Backward overlap: same data, Src=0x22, Dst=0x20, Len=4 → ascending; mem[0x20..0x23]=C,D,?,? matching the original mem[0x22..0x25].
- Wrap-around: Src=0xFE, Dst=0x80, Len=4 → reads 0xFE,0xFF,0x00,0x01 in order; mem[0x80..0x83] holds those bytes.
- Len=0 plus ignored Start: Len=0 → `Done` one cycle later, no writes. During a Len=8 copy, pulse `Start` with a different Src → the original copy completes unchanged.
- Reset mid-op: assert `Reset`=0 during the WRITE of byte 2 of a Len=6 copy → the next cycle has all outputs 0 and state IDLE; exactly the bytes committed before the reset edge are written; no `Done` pulse.

Source files
------------

// File: rtl/mem_block_mover_if.sv
// Memory port and control bundle shared by the block mover and its host.
// The mover drives the memory side; the host drives the request side.
interface mem_block_mover_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          Start;
    logic [AW-1:0] SrcAddr;
    logic [AW-1:0] DstAddr;
    logic [AW-1:0] Len;
    logic [AW-1:0] MemAddr;
    logic          MemWrEn;
    logic [DW-1:0] MemWrData;
    logic [DW-1:0] MemRdData;
    logic          Busy;
    logic          Done;

    modport master (
        input  Start, SrcAddr, DstAddr, Len, MemRdData,
        output MemAddr, MemWrEn, MemWrData, Busy, Done
    );

    modport slave (
        output Start, SrcAddr, DstAddr, Len, MemRdData,
        input  MemAddr, MemWrEn, MemWrData, Busy, Done
    );
endinterface

// File: rtl/mem_block_mover.sv
// Overlap-safe block copy engine on a single-address memory port.
// One byte per READ/WRITE pair; addresses wrap modulo 2^AW.
module mem_block_mover #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    mem_block_mover_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [AW-1:0] ONE = AW'(1);

    state_t        r_state;
    logic [AW-1:0] r_src;
    logic [AW-1:0] r_dst;
    logic [AW-1:0] r_rem;
    logic [AW-1:0] r_addr;
    logic          r_desc;
    logic          r_wr_en;
    logic          r_busy;
    logic          r_done;
    logic [DW-1:0] r_hold;

    logic [AW-1:0] w_diff;
    logic          w_desc;
    logic [AW-1:0] w_src0;
    logic [AW-1:0] w_dst0;
    logic [AW-1:0] w_src_nx;
    logic [AW-1:0] w_dst_nx;

    // Destination ahead of source within the block: copy from the top down
    assign w_diff   = bus.DstAddr - bus.SrcAddr;
    assign w_desc   = (bus.DstAddr != bus.SrcAddr) && (w_diff < bus.Len);
    assign w_src0   = w_desc ? bus.SrcAddr + bus.Len - ONE : bus.SrcAddr;
    assign w_dst0   = w_desc ? bus.DstAddr + bus.Len - ONE : bus.DstAddr;
    assign w_src_nx = r_desc ? r_src - ONE : r_src + ONE;
    assign w_dst_nx = r_desc ? r_dst - ONE : r_dst + ONE;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state <= IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_rem   <= '0;
            r_addr  <= '0;
            r_desc  <= 1'b0;
            r_wr_en <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hold  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.Start) begin
                        r_busy <= 1'b1;
                        if (bus.Len == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= READ;
                            r_src   <= w_src0;
                            r_dst   <= w_dst0;
                            r_rem   <= bus.Len;
                            r_desc  <= w_desc;
                            r_addr  <= w_src0;
                        end
                    end
                end
                READ: begin
                    r_state <= WRITE;
                    r_hold  <= bus.MemRdData;
                    r_addr  <= r_dst;
                    r_wr_en <= 1'b1;
                end
                WRITE: begin
                    r_src   <= w_src_nx;
                    r_dst   <= w_dst_nx;
                    r_rem   <= r_rem - ONE;
                    r_wr_en <= 1'b0;
                    r_hold  <= '0;
                    if (r_rem == ONE) begin
                        r_state <= DONE;
                        r_addr  <= '0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= READ;
                        r_addr  <= w_src_nx;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.MemAddr   = r_addr;
    assign bus.MemWrEn   = r_wr_en;
    assign bus.MemWrData = r_hold;
    assign bus.Busy      = r_busy;
    assign bus.Done      = r_done;
endmodule

// File: tb/tb_mem_block_mover.sv
// Bench for mem_block_mover: directed and random copies against a
// memmove reference computed from a snapshot of the memory array.
module tb_mem_block_mover;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_block_mover_if #(.AW(8), .DW(8)) bus ();

    mem_block_mover #(.AW(8), .DW(8)) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    logic [7:0] mem [256];
    logic [7:0] ref_m [256];
    logic [7:0] old_m [256];
    logic       ld_en = 1'b0;
    logic [7:0] ld_addr = '0;
    logic [7:0] ld_data = '0;
    logic [7:0] rq [$];
    logic [7:0] wq [$];
    int checks = 0;
    int failures = 0;

    assign bus.MemRdData = mem[bus.MemAddr];

    always @(posedge clk) begin
        if (bus.MemWrEn) mem[bus.MemAddr] <= bus.MemWrData;
        if (ld_en) mem[ld_addr] <= ld_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] v);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = v;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            ld_en = 1'b1; ld_addr = 8'(i); ld_data = 8'($urandom);
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic run_copy(input logic [7:0] s, input logic [7:0] d,
                            input logic [7:0] l, input bit poke);
        logic [7:0] tmp [256];
        int n, done_at, busy_cnt, errs;
        for (int i = 0; i < 256; i++) ref_m[i] = mem[i];
        for (int i = 0; i < int'(l); i++) tmp[i] = mem[8'(int'(s) + i)];
        for (int i = 0; i < int'(l); i++) ref_m[8'(int'(d) + i)] = tmp[i];
        rq.delete(); wq.delete();
        @(negedge clk);
        bus.Start = 1'b1; bus.SrcAddr = s; bus.DstAddr = d; bus.Len = l;
        @(negedge clk);
        bus.Start = 1'b0;
        n = 1; done_at = 0; busy_cnt = 0;
        while (n <= 600) begin
            if (bus.Busy) busy_cnt++;
            if (bus.MemWrEn) wq.push_back(bus.MemAddr);
            else if (bus.Busy && !bus.Done) rq.push_back(bus.MemAddr);
            if (bus.Done) begin
                done_at = n;
                break;
            end
            if (poke && n == 3) begin
                bus.Start = 1'b1; bus.SrcAddr = s + 8'h33; bus.Len = 8'd1;
            end else begin
                bus.Start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        bus.Start = 1'b0;
        chk("done_cycle", done_at, 1 + 2 * int'(l));
        chk("busy_cycles", busy_cnt, 1 + 2 * int'(l));
        chk("write_count", wq.size(), int'(l));
        @(negedge clk);
        chk("done_pulse", {bus.Done, bus.Busy}, 2'b00);
        chk("idle_outs", {bus.MemAddr, bus.MemWrEn, bus.MemWrData}, 0);
        errs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_m[i]) errs++;
        chk("mem_image", errs, 0);
    endtask

    initial begin
        bus.Start = 1'b0; bus.SrcAddr = '0; bus.DstAddr = '0; bus.Len = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {bus.MemAddr, bus.MemWrEn, bus.MemWrData,
                           bus.Busy, bus.Done}, 0);
        rst_n = 1'b1;
        fill_rand();

        // Basic ascending copy
        load(8'h10, 8'h11); load(8'h11, 8'h22);
        load(8'h12, 8'h33); load(8'h13, 8'h44);
        run_copy(8'h10, 8'h40, 8'd4, 1'b0);
        chk("asc_dst0", mem[8'h40], 8'h11);
        chk("asc_dst3", mem[8'h43], 8'h44);
        chk("asc_src0", mem[8'h10], 8'h11);

        // Forward overlap goes top-down
        load(8'h20, 8'hA1); load(8'h21, 8'hB2);
        load(8'h22, 8'hC3); load(8'h23, 8'hD4);
        run_copy(8'h20, 8'h22, 8'd4, 1'b0);
        chk("fwd_first_wr", wq[0], 8'h25);
        chk("fwd_m20", mem[8'h20], 8'hA1);
        chk("fwd_m21", mem[8'h21], 8'hB2);
        chk("fwd_m22", mem[8'h22], 8'hA1);
        chk("fwd_m23", mem[8'h23], 8'hB2);
        chk("fwd_m24", mem[8'h24], 8'hC3);
        chk("fwd_m25", mem[8'h25], 8'hD4);

        // Backward overlap goes bottom-up
        for (int i = 0; i < 256; i++) old_m[i] = mem[i];
        run_copy(8'h22, 8'h20, 8'd4, 1'b0);
        chk("bwd_first_wr", wq[0], 8'h20);
        for (int i = 0; i < 4; i++)
            chk("bwd_dst", mem[8'(8'h20 + i)], old_m[8'(8'h22 + i)]);

        // Wrap-around source
        run_copy(8'hFE, 8'h80, 8'd4, 1'b0);
        chk("wrap_rd0", rq[0], 8'hFE);
        chk("wrap_rd1", rq[1], 8'hFF);
        chk("wrap_rd2", rq[2], 8'h00);
        chk("wrap_rd3", rq[3], 8'h01);

        // Zero length, then ignored Start during a copy
        run_copy(8'h05, 8'h06, 8'd0, 1'b0);
        run_copy(8'h30, 8'hA0, 8'd8, 1'b1);

        // Reset during the write of byte 2
        fill_rand();
        for (int i = 0; i < 256; i++) old_m[i] = mem[i];
        @(negedge clk);
        bus.Start = 1'b1; bus.SrcAddr = 8'h60; bus.DstAddr = 8'h90;
        bus.Len = 8'd6;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_pre_wr", {bus.MemWrEn, bus.MemAddr}, {1'b1, 8'h92});
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_outs", {bus.MemAddr, bus.MemWrEn, bus.MemWrData,
                         bus.Busy, bus.Done}, 0);
        rst_n = 1'b1;
        begin
            int seen = 0;
            repeat (20) begin
                @(negedge clk);
                if (bus.Done || bus.MemWrEn || bus.Busy) seen++;
            end
            chk("rst_no_done", seen, 0);
        end
        chk("rst_b0", mem[8'h90], old_m[8'h60]);
        chk("rst_b1", mem[8'h91], old_m[8'h61]);
        for (int i = 3; i < 6; i++)
            chk("rst_untouched", mem[8'(8'h90 + i)], old_m[8'(8'h90 + i)]);

        // Random copies
        for (int t = 0; t < 8; t++) begin
            fill_rand();
            run_copy(8'($urandom), 8'($urandom),
                     8'($urandom_range(0, 40)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
